// File: rtl/dual_port_ram_2p.sv
// Purpose: 1-write/2-read RAM, port 0 read/write and port 1 read-only, with registered read data on both ports.
// Latency: 1 cycle from address/enable to data; a write is visible to either port on the following edge.
// Backpressure: none; every enabled cycle completes in one clock, and a disabled port holds its output.
module dual_port_ram_2p #(
    parameter int addr_width = 4,
    parameter int data_width = 8,
    parameter int depth      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [data_width-1:0] data_in,
    input  logic [addr_width-1:0] addr_in_0,
    input  logic [addr_width-1:0] addr_in_1,
    input  logic                  port_en_0,
    input  logic                  port_en_1,
    output logic [data_width-1:0] data_out_0,
    output logic [data_width-1:0] data_out_1
);

    localparam logic [addr_width:0] depth_lim = depth[addr_width:0];

    logic [data_width-1:0] mem [depth];
    logic                  in_range_0;
    logic                  in_range_1;

    // One spare bit keeps the compare meaningful when depth == 2**addr_width.
    assign in_range_0 = {1'b0, addr_in_0} < depth_lim;
    assign in_range_1 = {1'b0, addr_in_1} < depth_lim;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < depth; i++) begin
                mem[i] <= '0;
            end
            data_out_0 <= '0;
            data_out_1 <= '0;
        end else begin
            if (port_en_0) begin
                if (wr_en) begin
                    if (in_range_0) begin
                        mem[addr_in_0] <= data_in;
                    end
                end else begin
                    data_out_0 <= in_range_0 ? mem[addr_in_0] : '0;
                end
            end
            // Non-blocking write above means a same-address read here sees the old word.
            if (port_en_1) begin
                data_out_1 <= in_range_1 ? mem[addr_in_1] : '0;
            end
        end
    end

endmodule

// File: tb/tb_dual_port_ram_2p.sv
// Randomized and directed bench for dual_port_ram_2p, checked every cycle against an array model.
module tb_dual_port_ram_2p;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en;
    logic [DW-1:0] data_in;
    logic [AW-1:0] addr_in_0;
    logic [AW-1:0] addr_in_1;
    logic          port_en_0;
    logic          port_en_1;
    logic [DW-1:0] data_out_0;
    logic [DW-1:0] data_out_1;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    int model_mem [DEPTH];
    int exp0;
    int exp1;

    dual_port_ram_2p #(.addr_width(AW), .data_width(DW), .depth(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .data_in    (data_in),
        .addr_in_0  (addr_in_0),
        .addr_in_1  (addr_in_1),
        .port_en_0  (port_en_0),
        .port_en_1  (port_en_1),
        .data_out_0 (data_out_0),
        .data_out_1 (data_out_1)
    );

    always #5 clk = ~clk;

    // Reference: reads capture the array before this cycle's write lands.
    always @(posedge clk) begin
        int a0, a1;
        a0 = int'(addr_in_0);
        a1 = int'(addr_in_1);
        if (!rst_n) begin
            foreach (model_mem[i]) model_mem[i] = 0;
            exp0 = 0;
            exp1 = 0;
        end else begin
            if (port_en_1) exp1 = (a1 < DEPTH) ? model_mem[a1] : 0;
            if (port_en_0 && !wr_en) exp0 = (a0 < DEPTH) ? model_mem[a0] : 0;
            if (port_en_0 && wr_en && a0 < DEPTH) model_mem[a0] = int'(data_in);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_out0", int'(data_out_0), exp0);
            chk("model_out1", int'(data_out_1), exp1);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input bit rn, input bit pe0, input bit pe1, input bit we,
                         input int a0, input int a1, input int d);
        rst_n     = rn;
        port_en_0 = pe0;
        port_en_1 = pe1;
        wr_en     = we;
        addr_in_0 = AW'(a0);
        addr_in_1 = AW'(a1);
        data_in   = DW'(d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held for two edges while sweeping addresses.
        drive(0, 1, 1, 0, 0, 9, 0);
        tick();
        chk_en = 1'b1;
        chk("rst_out0_a", int'(data_out_0), 0);
        chk("rst_out1_a", int'(data_out_1), 0);
        drive(0, 1, 1, 0, 4, 13, 0);
        tick();
        chk("rst_out0_b", int'(data_out_0), 0);
        chk("rst_out1_b", int'(data_out_1), 0);

        for (int a = 0; a < DEPTH; a++) begin
            drive(1, 0, 1, 0, 0, a, 0);
            tick();
            chk("rst_clear", int'(data_out_1), 0);
        end

        // Fill word i-1 with value i.
        for (int i = 1; i <= DEPTH; i++) begin
            drive(1, 1, 0, 1, i - 1, 0, i);
            tick();
            chk("fill_hold0", int'(data_out_0), 0);
        end
        for (int a = 0; a < DEPTH; a++) begin
            drive(1, 0, 1, 0, 0, a, 0);
            tick();
            chk("readback", int'(data_out_1), a + 1);
            chk("readback_hold0", int'(data_out_0), 0);
        end

        drive(1, 1, 1, 0, 3, 12, 0);
        tick();
        chk("dual_out0", int'(data_out_0), 4);
        chk("dual_out1", int'(data_out_1), 13);

        // Same-address write and read: old data first, new data next edge.
        drive(1, 1, 1, 1, 5, 5, 'hAA);
        tick();
        chk("collide_old", int'(data_out_1), 6);
        chk("collide_hold0", int'(data_out_0), 4);
        drive(1, 1, 1, 0, 5, 5, 0);
        tick();
        chk("collide_new1", int'(data_out_1), 'hAA);
        chk("collide_new0", int'(data_out_0), 'hAA);

        drive(1, 0, 0, 1, 2, 0, 'h55);
        tick();
        drive(1, 1, 0, 0, 2, 1, 0);
        tick();
        chk("disabled_write", int'(data_out_0), 3);
        for (int a = 7; a < 11; a++) begin
            drive(1, 1, 0, 0, 2, a, 0);
            tick();
            chk("port1_hold", int'(data_out_1), 'hAA);
        end

        drive(0, 1, 1, 1, 7, 7, 'hFF);
        tick();
        chk("midrst_out0", int'(data_out_0), 0);
        chk("midrst_out1", int'(data_out_1), 0);
        drive(1, 1, 1, 0, 7, 7, 0);
        tick();
        chk("midrst_read0", int'(data_out_0), 0);
        chk("midrst_read1", int'(data_out_1), 0);

        for (int n = 0; n < 1500; n++) begin
            drive(($urandom_range(0, 99) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
                  int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, DEPTH - 1)),
                  int'($urandom_range(0, 255)));
            if ($urandom_range(0, 3) == 0) addr_in_1 = addr_in_0;
            tick();
        end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
